// File: rtl/uart_regs_pkg.sv
// ============================================================================
// uart_regs_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the UART peripheral register bank.
//
// Contents:
//   UART_DATA_W           default register / read-data width
//   REG_CTRL .. REG_BAUD  register index map of the UART register bank
//   rd_state_t            read-port response state (IDLE / RESP)
//   UART_COR_MASK_DEFAULT clear-on-read mask for the standard 4-register bank
//                         (only STATUS clears on read)
// ============================================================================
package uart_regs_pkg;

    // Default width of every UART register and of the read-data path.
    localparam int UART_DATA_W = 32;

    // Number of registers in the standard UART bank.
    localparam int UART_N_REGS = 4;

    // Register index map.
    localparam int REG_CTRL   = 0;
    localparam int REG_DATA   = 1;
    localparam int REG_STATUS = 2;
    localparam int REG_BAUD   = 3;

    // Read-port response state: IDLE holds no response, RESP presents one.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } rd_state_t;

    // STATUS carries sticky event flags that the owner clears once software
    // has read them, so it is the only clear-on-read register by default.
    localparam logic [UART_N_REGS-1:0] UART_COR_MASK_DEFAULT =
        UART_N_REGS'(1) << REG_STATUS;

endpackage : uart_regs_pkg

// File: rtl/uart_reg_rd_port.sv
// ============================================================================
// uart_reg_rd_port
// ----------------------------------------------------------------------------
// Registered read port for the UART register bank. A request is accepted
// when rd_req_i && rd_ready_o; one cycle later the selected register value
// is presented on rdata_o with rvalid_o high and is held until the consumer
// takes it (rvalid_o && rready_i). Out-of-range addresses return
// DEFAULT_DATA with rerr_o set. Registers flagged in COR_MASK get a one-cycle
// cor_clr_o pulse in the cycle after their read is accepted.
//
// Parameters:
//   DATA_W        register and read-data width
//   N_REGS        number of readable registers (>= 2)
//   ADDR_W        read address width
//   COR_MASK      bit k set -> register k is clear-on-read
//   DEFAULT_DATA  data returned for an invalid address
//
// Ports:
//   clk_i       in   clock, rising edge
//   rst_i       in   synchronous active-high reset
//   rd_req_i    in   read request
//   rd_addr_i   in   register index, sampled on accept
//   rd_ready_o  out  request can be accepted this cycle
//   regs_i      in   flattened register values, reg k at [k*DATA_W +: DATA_W]
//   rdata_o     out  response data
//   rvalid_o    out  response valid
//   rready_i    in   response consumed when rvalid_o && rready_i
//   rerr_o      out  response belongs to an invalid address
//   cor_clr_o   out  one-hot clear-on-read pulse, one cycle wide
// ============================================================================
module uart_reg_rd_port
    import uart_regs_pkg::*;
#(
    parameter int                 DATA_W       = UART_DATA_W,
    parameter int                 N_REGS       = 4,
    parameter int                 ADDR_W       = (N_REGS > 2) ? $clog2(N_REGS) : 1,
    parameter logic [N_REGS-1:0]  COR_MASK     = '0,
    parameter logic [31:0]        DEFAULT_DATA = 32'hDEAD_BEEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rd_req_i,
    input  logic [ADDR_W-1:0]        rd_addr_i,
    output logic                     rd_ready_o,
    input  logic [N_REGS*DATA_W-1:0] regs_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     rvalid_o,
    input  logic                     rready_i,
    output logic                     rerr_o,
    output logic [N_REGS-1:0]        cor_clr_o
);

    // Invalid-address data, resized to the data width (truncated when
    // DATA_W is below 32 bits, zero-extended above).
    localparam logic [DATA_W-1:0] DEFAULT_RD = DATA_W'(DEFAULT_DATA);

    rd_state_t           state;
    logic                accept;
    logic                addr_valid;
    logic [DATA_W-1:0]   sel_data;
    logic [N_REGS-1:0]   addr_onehot;

    // A new request can be taken whenever no response is pending, or when
    // the pending one is being consumed in this very cycle. The rready_i
    // term is what allows a read every cycle without a bubble.
    assign rd_ready_o = (state == IDLE) || rready_i;
    assign accept     = rd_req_i && rd_ready_o;
    assign rvalid_o   = (state == RESP);

    // Address range check; non-power-of-two banks leave unused codes.
    assign addr_valid = int'(rd_addr_i) < N_REGS;

    // Register selector. Each register is compared against the address and
    // picked with a constant part-select, so an out-of-range address can
    // never index outside regs_i; it simply falls back to DEFAULT_RD.
    always_comb begin
        sel_data    = DEFAULT_RD;
        addr_onehot = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (int'(rd_addr_i) == k) begin
                sel_data       = regs_i[k*DATA_W +: DATA_W];
                addr_onehot[k] = 1'b1;
            end
        end
    end

    // Response state and data capture. Data is captured in the accept cycle,
    // so later changes of regs_i (including the owner's clear triggered by
    // cor_clr_o) never disturb the value being returned. After a handshake
    // without a new accept, rdata_o/rerr_o keep their last values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            rdata_o <= '0;
            rerr_o  <= 1'b0;
        end else if (accept) begin
            state   <= RESP;
            rdata_o <= sel_data;
            rerr_o  <= !addr_valid;
        end else if ((state == RESP) && rready_i) begin
            state   <= IDLE;
        end
    end

    // Clear-on-read pulse, aligned with the response becoming valid. An
    // invalid address has an all-zero one-hot, so it never clears anything;
    // reset suppresses a pulse that would otherwise be due.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cor_clr_o <= '0;
        end else if (accept) begin
            cor_clr_o <= COR_MASK & addr_onehot;
        end else begin
            cor_clr_o <= '0;
        end
    end

endmodule : uart_reg_rd_port

// File: tb/tb_uart_reg_rd_port.sv
// ============================================================================
// tb_uart_reg_rd_port
// ----------------------------------------------------------------------------
// Two instances share clock, reset and handshake inputs:
//   dut4: N_REGS=4, COR_MASK=4'b0100 (STATUS clears on read)
//   dut3: N_REGS=3, COR_MASK=3'b011, address 3 is out of range
// Both are compared every cycle against a transaction-level reference model
// holding the pending response (valid/data/err) and the expected clear pulse.
// ============================================================================
module tb_uart_reg_rd_port;
    import uart_regs_pkg::*;

    localparam int DW = 32;
    localparam logic [3:0] COR4 = UART_COR_MASK_DEFAULT;
    localparam logic [2:0] COR3 = 3'b011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          rd_req;
    logic [1:0]    rd_addr;
    logic          rready;

    logic [DW-1:0] regs4 [4];
    logic [DW-1:0] regs3 [3];
    logic [4*DW-1:0] regs4_flat;
    logic [3*DW-1:0] regs3_flat;

    for (genvar k = 0; k < 4; k++) begin : g_pack4
        assign regs4_flat[k*DW +: DW] = regs4[k];
    end
    for (genvar k = 0; k < 3; k++) begin : g_pack3
        assign regs3_flat[k*DW +: DW] = regs3[k];
    end

    logic          ready4, ready3, rvalid4, rvalid3, rerr4, rerr3;
    logic [DW-1:0] rdata4, rdata3;
    logic [3:0]    cor4;
    logic [2:0]    cor3;

    uart_reg_rd_port #(.DATA_W(DW), .N_REGS(4), .ADDR_W(2), .COR_MASK(COR4),
                       .DEFAULT_DATA(32'hDEAD_BEEF)) dut4 (
        .clk_i(clk), .rst_i(rst), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
        .rd_ready_o(ready4), .regs_i(regs4_flat), .rdata_o(rdata4),
        .rvalid_o(rvalid4), .rready_i(rready), .rerr_o(rerr4), .cor_clr_o(cor4)
    );

    uart_reg_rd_port #(.DATA_W(DW), .N_REGS(3), .ADDR_W(2), .COR_MASK(COR3),
                       .DEFAULT_DATA(32'hDEAD_BEEF)) dut3 (
        .clk_i(clk), .rst_i(rst), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
        .rd_ready_o(ready3), .regs_i(regs3_flat), .rdata_o(rdata3),
        .rvalid_o(rvalid3), .rready_i(rready), .rerr_o(rerr3), .cor_clr_o(cor3)
    );

    // Reference model: the response currently owed to the consumer.
    logic          m_valid;
    logic [DW-1:0] m_data4, m_data3;
    logic          m_err4, m_err3;
    logic [3:0]    m_cor4;
    logic [2:0]    m_cor3;

    int n_checks = 0;
    int n_fails  = 0;

    // Single comparison point: counts and reports every check.
    task automatic check_output(input string tag, input logic [63:0] got,
                                input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h",
                     tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check the
    // combinational ready, advance the model, check registered outputs
    // just after the rising edge.
    task automatic apply_stimulus(input logic r, input logic req,
                                  input logic [1:0] a, input logic rr);
        logic acc;
        int   ai;
        @(negedge clk);
        rst = r; rd_req = req; rd_addr = a; rready = rr;
        #1;
        check_output("rd_ready4", 64'(ready4), 64'(!m_valid || rr));
        check_output("rd_ready3", 64'(ready3), 64'(!m_valid || rr));

        ai  = int'(a);
        acc = !r && req && (!m_valid || rr);
        if (r) begin
            m_valid = 1'b0;
            m_data4 = '0; m_data3 = '0;
            m_err4  = 1'b0; m_err3 = 1'b0;
            m_cor4  = '0; m_cor3 = '0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_data4 = regs4[ai];
            m_err4  = 1'b0;
            m_cor4  = COR4[ai] ? 4'(1 << ai) : 4'd0;
            if (ai < 3) begin
                m_data3 = regs3[ai];
                m_err3  = 1'b0;
                m_cor3  = COR3[ai] ? 3'(1 << ai) : 3'd0;
            end else begin
                m_data3 = 32'hDEAD_BEEF;
                m_err3  = 1'b1;
                m_cor3  = '0;
            end
        end else begin
            if (m_valid && rr) m_valid = 1'b0;
            m_cor4 = '0;
            m_cor3 = '0;
        end

        @(posedge clk);
        #1;
        check_output("rvalid4", 64'(rvalid4), 64'(m_valid));
        check_output("rvalid3", 64'(rvalid3), 64'(m_valid));
        check_output("rdata4",  64'(rdata4),  64'(m_data4));
        check_output("rdata3",  64'(rdata3),  64'(m_data3));
        check_output("rerr4",   64'(rerr4),   64'(m_err4));
        check_output("rerr3",   64'(rerr3),   64'(m_err3));
        check_output("cor4",    64'(cor4),    64'(m_cor4));
        check_output("cor3",    64'(cor3),    64'(m_cor3));
    endtask

    initial begin
        rst = 1'b1; rd_req = 1'b0; rd_addr = '0; rready = 1'b0;
        m_valid = 1'b0; m_data4 = '0; m_data3 = '0;
        m_err4 = 1'b0; m_err3 = 1'b0; m_cor4 = '0; m_cor3 = '0;
        for (int k = 0; k < 4; k++) regs4[k] = 32'h1000_0000 + 32'(k);
        for (int k = 0; k < 3; k++) regs3[k] = 32'h3000_0000 + 32'(k);

        // Reset state
        apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0);
        check_output("reset_ready", 64'(ready4), 64'(1));

        // Basic read of addr 2
        regs4[2] = 32'h1234_5678;
        regs3[2] = 32'h5555_6666;
        apply_stimulus(1'b0, 1'b1, 2'd2, 1'b1);
        check_output("basic_data", 64'(rdata4), 64'h1234_5678);
        check_output("basic_cor", 64'(cor4), 64'h4);

        // Backpressure: data held while regs change
        for (int i = 0; i < 3; i++) begin
            regs4[2] = 32'hAAAA_0000;
            apply_stimulus(1'b0, 1'b1, 2'd1, 1'b0);
            check_output("bp_ready", 64'(ready4), 64'(0));
            check_output("bp_data", 64'(rdata4), 64'h1234_5678);
        end
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1);
        check_output("bp_idle", 64'(rvalid4), 64'(0));

        // Back-to-back reads 0, 1, 3
        apply_stimulus(1'b0, 1'b1, 2'd0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 2'd1, 1'b1);
        apply_stimulus(1'b0, 1'b1, 2'd3, 1'b1);
        check_output("b2b_last", 64'(rdata4), 64'(regs4[3]));
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1);

        // Clear-on-read: addr 2 then addr 1
        apply_stimulus(1'b0, 1'b1, 2'd2, 1'b1);
        apply_stimulus(1'b0, 1'b1, 2'd1, 1'b1);
        check_output("cor_second", 64'(cor4), 64'(0));
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1);

        // Invalid address on the 3-register instance
        apply_stimulus(1'b0, 1'b1, 2'd3, 1'b1);
        check_output("inv_data", 64'(rdata3), 64'hDEAD_BEEF);
        check_output("inv_err", 64'(rerr3), 64'(1));
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1);

        // Reset during RESP, and a request presented with reset asserted
        apply_stimulus(1'b0, 1'b1, 2'd1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 2'd2, 1'b0);
        check_output("rst_resp_valid", 64'(rvalid4), 64'(0));
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) regs4[$urandom_range(0, 3)] = $urandom;
            if ($urandom_range(0, 3) == 0) regs3[$urandom_range(0, 2)] = $urandom;
            apply_stimulus(($urandom_range(0, 39) == 0),
                           1'($urandom_range(0, 1)),
                           2'($urandom_range(0, 3)),
                           ($urandom_range(0, 2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule : tb_uart_reg_rd_port

// File: doc/uart_reg_rd_port.md
# uart_reg_rd_port

Parametrised, registered read port for the UART peripheral register bank. It selects one of N_REGS register values by address, returns it through a valid/ready response handshake with one cycle of latency, and flags out-of-range addresses. It issues clear-on-read pulses back to the register owners. It sits between the bus slave decode and the UART control, data and status registers.

## Interface

- DATA_W, 32, register and read-data width
- N_REGS, 4, number of readable registers (≥2)
- ADDR_W, $clog2(N_REGS) (min 1), read address width
- COR_MASK, '0, N_REGS-bit mask; bit k=1 marks register k clear-on-read
- DEFAULT_DATA, 32'hDEAD_BEEF, data returned for an invalid address (truncated to DATA_W)

Ports:

- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- rd_req_i  in  1  read request
- rd_addr_i  in  ADDR_W  register index, sampled on accept
- rd_ready_o  out  1  request accepted when rd_req_i && rd_ready_o
- regs_i  in  N_REGS*DATA_W  register values, flattened; register k occupies bits [k*DATA_W +: DATA_W]
- rdata_o  out  DATA_W  response data
- rvalid_o  out  1  response valid
- rready_i  in  1  response consumed when rvalid_o && rready_i
- rerr_o  out  1  response is for an invalid address, qualified by rvalid_o
- cor_clr_o  out  N_REGS  one-hot clear-on-read pulse, 1 cycle

## Operation

- FSM states are IDLE (no response held) and RESP (rvalid_o=1).
- rd_ready_o = (state==IDLE) || rready_i. This output is combinational from rready_i, so back-to-back reads are possible.
- On accept, the block registers the following:
  - rdata_o ← regs_i[rd_addr_i] if rd_addr_i < N_REGS, else DEFAULT_DATA.
  - rerr_o ← (rd_addr_i ≥ N_REGS).
  - The next state is RESP.
- In RESP without handshake, rdata_o and rerr_o are held stable and rvalid_o stays 1.
- In RESP with handshake and no new accept, the next state is IDLE, rvalid_o goes to 0, and rdata_o and rerr_o keep their last values.
- If a handshake and a new accept happen in the same cycle, the block stays in RESP and loads the new data.
- cor_clr_o[k] pulses for one cycle in the cycle after accept when all of the following hold:
  - COR_MASK[k]=1
  - the address is valid
  - k = rd_addr_i
- The returned data is always the pre-clear value, because it is captured in the accept cycle.
- An invalid address produces no cor_clr_o pulse.
- regs_i changes while in RESP do not affect the held rdata_o.

## Timing

- Reset values: rdata_o=0, rvalid_o=0, rerr_o=0, cor_clr_o=0, state=IDLE. rd_ready_o is therefore 1 after reset.
- Reset asserted during RESP drops the pending response with no cor_clr_o pulse. A cor_clr_o pulse due in the reset cycle is suppressed.
- Latency is 1 cycle: an accept at edge n gives rvalid_o=1 and cor_clr_o after edge n.
- Throughput is 1 read per cycle while rready_i=1.
- rd_addr_i is only sampled on accept and is don't-care otherwise.

## Structure

- The shared package uart_regs_pkg holds:
  - the DATA_W default
  - register index constants REG_CTRL=0, REG_DATA=1, REG_STATUS=2, REG_BAUD=3
  - the rd_state_t enum {IDLE, RESP}
  - a default COR_MASK constant with the STATUS bit set
- No sub-module. The selector is an inline indexed part-select with an address range check.

## Test plan

- **Reset:** assert rst_i mid-RESP -> rvalid_o=0, rdata_o=0, rd_ready_o=1 the next cycle, and no cor_clr_o pulse.
- **Basic read:** N_REGS=4, regs_i[2]=32'h1234_5678, read addr 2 with rready_i=1 -> rdata_o=32'h1234_5678 and rvalid_o=1 one cycle later, rerr_o=0.
- **Backpressure:** rready_i=0 for 3 cycles while regs_i[2] changes to 32'hAAAA_0000 -> rdata_o stays 32'h1234_5678 and rd_ready_o=0; then rready_i=1 completes the read and the block returns to IDLE.
- **Back-to-back:** rready_i=1, requests to addr 0,1,3 on consecutive cycles -> three consecutive valid responses carrying regs_i[0], regs_i[1], regs_i[3] with no bubble.
- **Clear-on-read:** COR_MASK=4'b0100, reads of addr 2 then addr 1 -> cor_clr_o=4'b0100 exactly one cycle after the first accept and 0 for the second read; the returned data is the pre-clear value.
- **Invalid address:** N_REGS=3 (ADDR_W=2), read addr 3 -> rdata_o=32'hDEAD_BEEF, rerr_o=1, cor_clr_o=0.
